// File: rtl/fpmul_op_issuer.sv
// fpmul_op_issuer: buffers host operand pairs, issues them one at a time to the multiplier and returns tagged results.
// Optional FPMUL_ISSUER_THROTTLE_EN: LFSR-driven res_ready back-pressure in WAIT_RES.
module fpmul_op_issuer #(
   parameter int DATA_W      = 32,
   parameter int FIFO_DEPTH  = 4,
   parameter int TAG_W       = 8,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              host_valid_i,
   output logic              host_ready_o,
   input  logic [DATA_W-1:0] host_a_i,
   input  logic [DATA_W-1:0] host_b_i,
   output logic              op_valid_o,
   input  logic              op_ready_i,
   output logic [DATA_W-1:0] op_a_o,
   output logic [DATA_W-1:0] op_b_o,
   input  logic              res_valid_i,
   output logic              res_ready_o,
   input  logic [DATA_W-1:0] res_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [TAG_W-1:0]  out_tag_o,
   output logic              out_timeout_o,
   output logic              busy_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT_CYC);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES, DELIVER} state_t;
   state_t state_q, state_d;
   logic [DATA_W-1:0] mem_a [FIFO_DEPTH];
   logic [DATA_W-1:0] mem_b [FIFO_DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic rdy_q, push, pop, res_xfer;
   logic op_valid_q, op_valid_d, out_valid_q, out_valid_d, out_timeout_q, out_timeout_d;
   logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d, out_data_q, out_data_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   assign push     = host_valid_i & rdy_q;
   assign res_xfer = res_valid_i & res_ready_o;
   assign cnt_d    = cnt_q + CW'(push) - CW'(pop);
   always_ff @(posedge clk) begin
      if (push) begin
         mem_a[wr_q] <= host_a_i;
         mem_b[wr_q] <= host_b_i;
      end
   end
   // host_ready is registered from the next-state count so it never depends on host_valid
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         rdy_q <= 1'b0;
      end else begin
         wr_q  <= wr_q + AW'(push);
         rd_q  <= rd_q + AW'(pop);
         cnt_q <= cnt_d;
         rdy_q <= cnt_d != CW'(FIFO_DEPTH);
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         op_valid_q    <= 1'b0;
         op_a_q        <= '0;
         op_b_q        <= '0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         out_timeout_q <= 1'b0;
         tag_q         <= '0;
         tcnt_q        <= '0;
      end else begin
         state_q       <= state_d;
         op_valid_q    <= op_valid_d;
         op_a_q        <= op_a_d;
         op_b_q        <= op_b_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         out_timeout_q <= out_timeout_d;
         tag_q         <= tag_d;
         tcnt_q        <= tcnt_d;
      end
   end
   always_comb begin
      state_d       = state_q;
      pop           = 1'b0;
      op_valid_d    = op_valid_q;
      op_a_d        = op_a_q;
      op_b_d        = op_b_q;
      out_valid_d   = out_valid_q;
      out_data_d    = out_data_q;
      out_timeout_d = out_timeout_q;
      tag_d         = tag_q;
      tcnt_d        = tcnt_q;
      case (state_q)
         IDLE: if (cnt_q != '0) begin
            pop        = 1'b1;
            op_a_d     = mem_a[rd_q];
            op_b_d     = mem_b[rd_q];
            op_valid_d = 1'b1;
            state_d    = ISSUE;
         end
         ISSUE: if (op_ready_i) begin
            op_valid_d = 1'b0;
            tcnt_d     = '0;
            state_d    = WAIT_RES;
         end
         WAIT_RES: begin
            tcnt_d = tcnt_q + 1'b1;
            // a result arriving on the final timeout cycle still wins
            if (res_xfer || tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
               out_data_d    = res_xfer ? res_data_i : '0;
               out_timeout_d = !res_xfer;
               out_valid_d   = 1'b1;
               state_d       = DELIVER;
            end
         end
         DELIVER: if (out_ready_i) begin
            out_valid_d = 1'b0;
            tag_d       = tag_q + 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
`ifdef FPMUL_ISSUER_THROTTLE_EN
   logic [7:0] lfsr_q;
   always_ff @(posedge clk) begin
      if (rst) lfsr_q <= 8'hA5;
      else lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   end
   assign res_ready_o = (state_q == WAIT_RES) & lfsr_q[0];
`else
   assign res_ready_o = state_q == WAIT_RES;
`endif
   assign host_ready_o  = rdy_q;
   assign op_valid_o    = op_valid_q;
   assign op_a_o        = op_a_q;
   assign op_b_o        = op_b_q;
   assign out_valid_o   = out_valid_q;
   assign out_data_o    = out_data_q;
   assign out_tag_o     = tag_q;
   assign out_timeout_o = out_timeout_q;
   assign busy_o        = (state_q != IDLE) | (cnt_q != '0);
endmodule

// File: tb/tb_fpmul_op_issuer.sv
// tb_fpmul_op_issuer: directed table-driven bench acting as host and multiplier for fpmul_op_issuer.
module tb_fpmul_op_issuer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic host_valid = 1'b1, host_ready, op_valid, op_ready = 1'b0, res_valid = 1'b0, res_ready;
   logic out_valid, out_ready = 1'b0, out_timeout, busy;
   logic [31:0] host_a = '0, host_b = '0, op_a, op_b, res_data = '0, out_data;
   logic [7:0] out_tag, exp_tag;
   int pass_n = 0, tot_n = 0;
   typedef struct {
      logic [31:0] a, b, r;
      int          dly;
      logic [31:0] d;
      logic        to;
   } vec_t;
   vec_t vt[6];
   always #5 clk = ~clk;
   fpmul_op_issuer dut (
      .clk(clk), .rst(rst),
      .host_valid_i(host_valid), .host_ready_o(host_ready), .host_a_i(host_a), .host_b_i(host_b),
      .op_valid_o(op_valid), .op_ready_i(op_ready), .op_a_o(op_a), .op_b_o(op_b),
      .res_valid_i(res_valid), .res_ready_o(res_ready), .res_data_i(res_data),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
      .out_tag_o(out_tag), .out_timeout_o(out_timeout), .busy_o(busy)
   );
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tot_n++;
      if (act === exp) pass_n++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask
   task automatic push(input logic [31:0] a, input logic [31:0] b);
      int n;
      n = 0;
      host_valid = 1'b1;
      host_a = a;
      host_b = b;
      while (!host_ready && n < 100) begin tick(); n++; end
      chk("push_wait", n < 100, 1);
      tick();
      host_valid = 1'b0;
   endtask
   task automatic issue(input logic [31:0] a, input logic [31:0] b);
      int n;
      n = 0;
      while (!op_valid && n < 100) begin tick(); n++; end
      chk("op_wait", n < 100, 1);
      chk("op_a", op_a, a);
      chk("op_b", op_b, b);
      op_ready = 1'b1;
      tick();
      op_ready = 1'b0;
      chk("op_valid_drop", op_valid, 0);
`ifndef FPMUL_ISSUER_THROTTLE_EN
      chk("res_ready_wait", res_ready, 1);
`endif
   endtask
   task automatic respond(input logic [31:0] r, input int dly);
      int n;
      n = 0;
      if (dly < 64) begin
         repeat (dly) tick();
         res_valid = 1'b1;
         res_data = r;
         while (!res_ready && n < 200) begin tick(); n++; end
         tick();
         res_valid = 1'b0;
      end
   endtask
   task automatic collect(input logic [31:0] d, input logic to, input int hold);
      int n;
      logic ok;
      n = 0;
      ok = 1'b1;
      while (!out_valid && n < 200) begin tick(); n++; end
      chk("out_wait", n < 200, 1);
      if (to) chk("timeout_cycles", n, 64);
      chk("out_data", out_data, d);
      chk("out_tag", out_tag, exp_tag);
      chk("out_timeout", out_timeout, to);
      repeat (hold) begin
         tick();
         if (!out_valid || out_data !== d || out_tag !== exp_tag || op_valid) ok = 1'b0;
      end
      if (hold > 0) chk("deliver_hold", ok, 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("out_valid_drop", out_valid, 0);
      exp_tag++;
   endtask
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      logic [31:0] pa [5];
      logic ok;
      vt[0] = '{32'h40000000, 32'h40400000, 32'h40C00000, 0,   32'h40C00000, 1'b0};
      vt[1] = '{32'h3FC00000, 32'h40000000, 32'h40400000, 3,   32'h40400000, 1'b0};
      vt[2] = '{32'hBF800000, 32'h40800000, 32'hC0800000, 1,   32'hC0800000, 1'b0};
      vt[3] = '{32'h3F000000, 32'h3F000000, 32'h3E800000, 63,  32'h3E800000, 1'b0};
      vt[4] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 100, 32'h00000000, 1'b1};
      vt[5] = '{32'h41200000, 32'h41200000, 32'h42C80000, 2,   32'h42C80000, 1'b0};
      exp_tag = 8'd0;
      repeat (3) tick();
      chk("rst_host_ready", host_ready, 0);
      chk("rst_op_valid", op_valid, 0);
      chk("rst_res_ready", res_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_timeout", out_timeout, 0);
      chk("rst_op_a", op_a, 0);
      chk("rst_op_b", op_b, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_tag", out_tag, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;
      host_valid = 1'b0;
      tick();
      chk("post_rst_host_ready", host_ready, 1);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_op_valid", op_valid, 0);
      for (int i = 0; i < 6; i++) begin
         push(vt[i].a, vt[i].b);
         issue(vt[i].a, vt[i].b);
         respond(vt[i].r, vt[i].dly);
         collect(vt[i].d, vt[i].to, 0);
      end
      push(32'h40A00000, 32'h40000000);
      push(32'h40E00000, 32'h3F800000);
      issue(32'h40A00000, 32'h40000000);
      respond(32'h41200000, 0);
      collect(32'h41200000, 1'b0, 10);
      issue(32'h40E00000, 32'h3F800000);
      respond(32'h40E00000, 0);
      collect(32'h40E00000, 1'b0, 0);
      for (int i = 0; i < 5; i++) pa[i] = 32'h1000 + 32'(i);
      push(32'hAAAA0000, 32'hBBBB0000);
      issue(32'hAAAA0000, 32'hBBBB0000);
      respond(32'hCCCC0000, 0);
      for (int i = 0; i < 4; i++) push(pa[i], ~pa[i]);
      chk("fifo_full_ready", host_ready, 0);
      host_valid = 1'b1;
      host_a = pa[4];
      host_b = ~pa[4];
      ok = 1'b1;
      repeat (3) begin tick(); if (host_ready || op_valid) ok = 1'b0; end
      chk("fifo_full_hold", ok, 1);
      collect(32'hCCCC0000, 1'b0, 0);
      push(pa[4], ~pa[4]);
      for (int i = 0; i < 5; i++) begin
         issue(pa[i], ~pa[i]);
         respond(pa[i] * 3, 0);
         collect(pa[i] * 3, 1'b0, 0);
      end
      for (int i = 0; i < 260; i++) begin
         push(32'(i), ~32'(i));
         issue(32'(i), ~32'(i));
         respond(32'(i) * 7, 0);
         collect(32'(i) * 7, 1'b0, 0);
      end
      push(32'h12345678, 32'h9ABCDEF0);
      issue(32'h12345678, 32'h9ABCDEF0);
      repeat (5) tick();
      chk("mid_busy", busy, 1);
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      tick();
      exp_tag = 8'd0;
      chk("midrst_busy", busy, 0);
      chk("midrst_res_ready", res_ready, 0);
      chk("midrst_host_ready", host_ready, 1);
      ok = 1'b1;
      repeat (5) begin tick(); if (out_valid || op_valid) ok = 1'b0; end
      chk("midrst_no_beat", ok, 1);
      push(32'h40000000, 32'h40400000);
      issue(32'h40000000, 32'h40400000);
      respond(32'h40C00000, 0);
      collect(32'h40C00000, 1'b0, 0);
      $display("%0d/%0d checks passed", pass_n, tot_n);
      $finish;
   end
endmodule
